quadrant_restorer: RTL and testbench

//  Back end of angle reduction: re-applies the quadrant that the front-end reducer stripped off.

---
 rtl/quadrant_restorer.sv | 81 ++++++++
 tb/tb_quadrant_restorer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/quadrant_restorer.sv
// quadrant_restorer: pairs queued quadrant tags with reduced-angle sin/cos/tan and restores their signs.
module quadrant_restorer #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_DEPTH  = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  tag_valid,
  output logic                  tag_ready,
  input  logic [1:0]            tag_quadrant,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] sin_in,
  input  logic [DATA_WIDTH-1:0] cos_in,
  input  logic [DATA_WIDTH-1:0] tan_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sin_out,
  output logic [DATA_WIDTH-1:0] cos_out,
  output logic [DATA_WIDTH-1:0] tan_out,
  output logic [1:0]            out_quadrant,
  output logic [CNT_W-1:0]      tag_count
);
  localparam int AW = $clog2(TAG_DEPTH);
  logic [1:0]            r_mem [TAG_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_sin, r_cos, r_tan;
  logic [1:0]            r_q;
  logic                  w_push, w_pop;
  logic [1:0]            w_q;
  // Signed zero collapses to +0.0 regardless of the quadrant flip.
  function automatic logic [DATA_WIDTH-1:0] fix(input logic [DATA_WIDTH-1:0] v, input logic neg);
    fix = (v[DATA_WIDTH-2:0] == '0) ? '0 : {v[DATA_WIDTH-1] ^ neg, v[DATA_WIDTH-2:0]};
  endfunction
  assign tag_ready    = r_count != CNT_W'(TAG_DEPTH);
  assign res_ready    = (r_count != '0) & (~r_out_valid | out_ready);
  assign w_push       = tag_valid & tag_ready;
  assign w_pop        = res_valid & res_ready;
  assign w_q          = r_mem[r_rptr];
  assign tag_count    = r_count;
  assign out_valid    = r_out_valid;
  assign sin_out      = r_sin;
  assign cos_out      = r_cos;
  assign tan_out      = r_tan;
  assign out_quadrant = r_q;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= tag_quadrant;
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  // sin negates in the lower half-plane, cos in the left half-plane, tan where exactly one does.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_out_valid <= 1'b0;
      r_sin       <= '0;
      r_cos       <= '0;
      r_tan       <= '0;
      r_q         <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_sin       <= fix(sin_in, w_q[1]);
      r_cos       <= fix(cos_in, w_q[1] ^ w_q[0]);
      r_tan       <= fix(tan_in, w_q[0]);
      r_q         <= w_q;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_quadrant_restorer.sv
// tb_quadrant_restorer: randomized and directed checks against a queue-based trig-identity model.
module tb_quadrant_restorer;
  logic        clk = 0, reset_n = 0, flush = 0;
  logic        tag_valid = 0, tag_ready, res_valid = 0, res_ready, out_valid, out_ready = 0;
  logic [1:0]  tag_quadrant = 0, out_quadrant;
  logic [63:0] sin_in = 0, cos_in = 0, tan_in = 0, sin_out, cos_out, tan_out;
  logic [3:0]  tag_count;
  int n_cmp = 0, n_fail = 0;
  localparam logic [63:0] S = 64'h3FE0000000000000, C = 64'h3FEBB67AE8584CAA, T = 64'h3FE279A74590331C;
  quadrant_restorer dut (.clk(clk), .reset_n(reset_n), .flush(flush), .tag_valid(tag_valid),
    .tag_ready(tag_ready), .tag_quadrant(tag_quadrant), .res_valid(res_valid), .res_ready(res_ready),
    .sin_in(sin_in), .cos_in(cos_in), .tan_in(tan_in), .out_valid(out_valid), .out_ready(out_ready),
    .sin_out(sin_out), .cos_out(cos_out), .tan_out(tan_out), .out_quadrant(out_quadrant),
    .tag_count(tag_count));
  always #5 clk = ~clk;
  // Model: original angle x per quadrant; sin(180-r)=sin r, cos(180-r)=-cos r, etc.
  bit sin_neg [4] = '{0, 0, 1, 1};
  bit cos_neg [4] = '{0, 1, 1, 0};
  bit tan_neg [4] = '{0, 1, 0, 1};
  int          mtags [$];
  bit          mv;
  logic [63:0] ms, mc, mt;
  logic [1:0]  mq;
  bit          exp_tr, exp_rr, got_tr, got_rr;
  function automatic logic [63:0] restore(input logic [63:0] v, input bit neg);
    logic [63:0] r;
    r = v;
    if (neg) r[63] = ~r[63];
    if (v[62:0] == 63'd0) r = 64'd0;
    return r;
  endfunction
  task automatic model_clear();
    mtags.delete();
    mv = 0; ms = 0; mc = 0; mt = 0; mq = 0;
  endtask
  task automatic drive(input bit tv, input logic [1:0] tq, input bit rv, input logic [63:0] s,
                       input logic [63:0] c, input logic [63:0] t, input bit ordy, input bit fl);
    int h;
    tag_valid = tv; tag_quadrant = tq; res_valid = rv; sin_in = s; cos_in = c; tan_in = t;
    out_ready = ordy; flush = fl;
    #1;
    exp_tr = mtags.size() != 8;
    exp_rr = mtags.size() != 0 && (!mv || ordy);
    got_tr = tag_ready; got_rr = res_ready;
    @(posedge clk); #1;
    if (!reset_n || fl) model_clear();
    else begin
      if (rv && exp_rr) begin
        h = mtags.pop_front();
        mv = 1; mq = 2'(h);
        ms = restore(s, sin_neg[h]); mc = restore(c, cos_neg[h]); mt = restore(t, tan_neg[h]);
      end else if (ordy) mv = 0;
      if (tv && exp_tr) mtags.push_back(int'(tq));
    end
  endtask
  task automatic idle(input bit ordy);
    drive(0, 0, 0, 0, 0, 0, ordy, 0);
  endtask
  task automatic test_reset();
    reset_n = 0;
    idle(0); idle(0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (tag_count !== 4'd0) begin n_fail++; $display("FAIL reset_tag_count got %0d want 0", tag_count); end
    n_cmp++; if ({sin_out, cos_out, tan_out, out_quadrant} !== '0) begin n_fail++; $display("FAIL reset_data got %h %h %h %b want 0", sin_out, cos_out, tan_out, out_quadrant); end
    n_cmp++; if (tag_ready !== 1'b1 || res_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b want 10", tag_ready, res_ready); end
    reset_n = 1;
    idle(1);
  endtask
  task automatic test_basic();
    logic [63:0] ws [4] = '{S, S, 64'hBFE0000000000000, 64'hBFE0000000000000};
    logic [63:0] wc [4] = '{C, 64'hBFEBB67AE8584CAA, 64'hBFEBB67AE8584CAA, C};
    for (int q = 0; q < 4; q++) begin
      drive(1, 2'(q), 0, 0, 0, 0, 1, 0);
      drive(0, 0, 1, S, C, T, 1, 0);
      n_cmp++; if (got_rr !== 1'b1) begin n_fail++; $display("FAIL basic_res_ready q=%0d got %b want 1", q, got_rr); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency q=%0d out_valid got %b want 1", q, out_valid); end
      n_cmp++; if (sin_out !== ws[q] || cos_out !== wc[q]) begin n_fail++; $display("FAIL basic_sincos q=%0d got %h %h want %h %h", q, sin_out, cos_out, ws[q], wc[q]); end
      n_cmp++; if (tan_out !== mt || out_quadrant !== 2'(q)) begin n_fail++; $display("FAIL basic_tan q=%0d got %h %b want %h %b", q, tan_out, out_quadrant, mt, 2'(q)); end
    end
    idle(1);
  endtask
  task automatic test_full();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) drive(1, 2'($urandom), 0, 0, 0, 0, 1, 0);
    n_cmp++; if (tag_count !== 4'd8 || tag_ready !== 1'b0) begin n_fail++; $display("FAIL full_count got %0d/%b want 8/0", tag_count, tag_ready); end
    drive(1, 2'd1, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (got_tr !== 1'b0 || tag_count !== 4'd8) begin n_fail++; $display("FAIL full_ninth got %b/%0d want 0/8", got_tr, tag_count); end
    drive(0, 0, 1, S, C, T, 1, 0);
    n_cmp++; if (tag_ready !== 1'b1 || tag_count !== 4'd7) begin n_fail++; $display("FAIL full_pop got %b/%0d want 1/7", tag_ready, tag_count); end
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, {1'b0, 63'($urandom)}, {1'b1, 63'($urandom)}, 64'($urandom), 1, 0);
      n_cmp++; if ({sin_out, cos_out, tan_out, out_quadrant} !== {ms, mc, mt, mq}) begin n_fail++; $display("FAIL full_drain %0d got %h %h %h %b want %h %h %h %b", i, sin_out, cos_out, tan_out, out_quadrant, ms, mc, mt, mq); end
    end
    idle(1);
  endtask
  task automatic test_stall();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, S, C, T, 1, 0);
      n_cmp++; if (got_rr !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty %0d got %b/%b want 0/0", i, got_rr, out_valid); end
    end
    drive(1, 2'd2, 1, S, C, T, 1, 0);
    n_cmp++; if (got_rr !== 1'b0) begin n_fail++; $display("FAIL stall_no_forward got %b want 0", got_rr); end
    drive(0, 0, 1, S, C, T, 1, 0);
    n_cmp++; if (got_rr !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after got %b want 1", got_rr); end
    n_cmp++; if (out_valid !== 1'b1 || sin_out !== 64'hBFE0000000000000) begin n_fail++; $display("FAIL stall_sin got %b %h want 1 bfe0000000000000", out_valid, sin_out); end
    idle(1);
  endtask
  task automatic test_backpressure();
    logic [63:0] s1, s2;
    s1 = 64'h3FD0000000000000; s2 = 64'h3FC0000000000000;
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 2'd1, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd3, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, s1, C, T, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, s2, C, T, 0, 0);
      n_cmp++; if (got_rr !== 1'b0) begin n_fail++; $display("FAIL bp_res_ready %0d got %b want 0", i, got_rr); end
      n_cmp++; if (out_valid !== 1'b1 || sin_out !== s1 || out_quadrant !== 2'd1) begin n_fail++; $display("FAIL bp_hold %0d got %b %h %b want 1 %h 01", i, out_valid, sin_out, out_quadrant, s1); end
    end
    drive(0, 0, 1, s2, C, T, 1, 0);
    n_cmp++; if (got_rr !== 1'b1 || out_valid !== 1'b1 || sin_out !== {1'b1, s2[62:0]} || out_quadrant !== 2'd3) begin n_fail++; $display("FAIL bp_second got %b %b %h %b want 1 1 %h 11", got_rr, out_valid, sin_out, out_quadrant, {1'b1, s2[62:0]}); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask
  task automatic test_zero_flush();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 2'd1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 64'h8000000000000000, 64'h0, 64'h8000000000000000, 1, 0);
    n_cmp++; if (cos_out !== 64'h0 || sin_out !== 64'h0 || tan_out !== 64'h0) begin n_fail++; $display("FAIL zero got %h %h %h want 0 0 0", sin_out, cos_out, tan_out); end
    for (int i = 0; i < 3; i++) drive(1, 2'(i), 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, S, C, T, 0, 0);
    drive(1, 2'd3, 1, S, C, T, 1, 1);
    n_cmp++; if (tag_count !== 4'd0 || out_valid !== 1'b0 || sin_out !== 64'h0) begin n_fail++; $display("FAIL flush got %0d %b %h want 0 0 0", tag_count, out_valid, sin_out); end
  endtask
  task automatic test_random();
    logic [63:0] v [3];
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        v[k] = {$urandom, $urandom};
        if ($urandom_range(9) == 0) v[k][62:0] = 63'd0;
        if ($urandom_range(9) == 0) v[k][62:52] = 11'h7FF;
      end
      drive($urandom_range(9) < 6, 2'($urandom), $urandom_range(1), v[0], v[1], v[2],
            $urandom_range(9) < (i < 300 ? 3 : 8), $urandom_range(199) == 0);
      n_cmp++; if (got_tr !== exp_tr || got_rr !== exp_rr) begin n_fail++; $display("FAIL rand_ready %0d got %b%b want %b%b", i, got_tr, got_rr, exp_tr, exp_rr); end
      n_cmp++; if (out_valid !== mv || tag_count !== 4'(mtags.size())) begin n_fail++; $display("FAIL rand_state %0d got %b/%0d want %b/%0d", i, out_valid, tag_count, mv, mtags.size()); end
      n_cmp++; if ({sin_out, cos_out, tan_out, out_quadrant} !== {ms, mc, mt, mq}) begin n_fail++; $display("FAIL rand_data %0d got %h %h %h %b want %h %h %h %b", i, sin_out, cos_out, tan_out, out_quadrant, ms, mc, mt, mq); end
    end
  endtask
  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_backpressure();
    test_zero_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
